// File: rtl/fpu_round_pack_pkg.sv
// ---------------------------------------------------------------------------
// fpu_pkg
// Shared types and constants for the single-precision round/pack stage.
//   rm_e       : IEEE-754 rounding mode as carried on the 2-bit i_rm bus
//   fflags_t   : {ovf, unf, nx} exception flag group
//   EXP_MAX    : all-ones biased exponent (inf/NaN encoding)
//   MAX_FINITE : magnitude of the largest finite single
//   POS_INF    : magnitude of infinity
//   ovf_magnitude() : magnitude returned on overflow for a mode and sign
// ---------------------------------------------------------------------------
package fpu_pkg;

    typedef enum logic [1:0] {
        RNE = 2'd0,
        RTZ = 2'd1,
        RUP = 2'd2,
        RDN = 2'd3
    } rm_e;

    typedef struct packed {
        logic ovf;
        logic unf;
        logic nx;
    } fflags_t;

    localparam logic [7:0]  EXP_MAX    = 8'hFF;
    localparam logic [30:0] MAX_FINITE = 31'h7F7FFFFF;
    localparam logic [30:0] POS_INF    = 31'h7F800000;

    // On overflow a result goes to infinity only when the rounding direction
    // points away from zero for that sign; otherwise it saturates at the
    // largest finite magnitude.
    function automatic logic [30:0] ovf_magnitude(input rm_e rm, input logic sign);
        logic to_inf;
        case (rm)
            RNE:     to_inf = 1'b1;
            RTZ:     to_inf = 1'b0;
            RUP:     to_inf = ~sign;
            RDN:     to_inf = sign;
            default: to_inf = 1'b1;
        endcase
        return to_inf ? POS_INF : MAX_FINITE;
    endfunction

endpackage

// File: rtl/fpu_round_pack_if.sv
// ---------------------------------------------------------------------------
// fpu_round_pack_if
// Bus bundle between the normalizer, the round/pack stage and its consumer.
//   Input side : i_valid/o_ready handshake, i_sign, i_exp, i_mant (with G/R/S),
//                i_overflow, i_underflow, i_rm
//   Output side: o_valid/i_ready handshake, o_result, per-result flags
//   Sticky     : i_clr_flags, o_fflags {ovf, unf, nx}
// Modports: slave = the round/pack stage, master = its environment.
// ---------------------------------------------------------------------------
interface fpu_round_pack_if
    import fpu_pkg::*;
#(
    parameter int MANT_W = 28,
    parameter int EXP_W  = 8
);
    logic              i_valid;
    logic              o_ready;
    logic              i_sign;
    logic [EXP_W-1:0]  i_exp;
    logic [MANT_W-1:0] i_mant;
    logic              i_overflow;
    logic              i_underflow;
    logic [1:0]        i_rm;

    logic              o_valid;
    logic              i_ready;
    logic [31:0]       o_result;
    logic              o_flag_ovf;
    logic              o_flag_unf;
    logic              o_flag_nx;

    logic              i_clr_flags;
    fflags_t           o_fflags;

    modport slave (
        input  i_valid, i_sign, i_exp, i_mant, i_overflow, i_underflow, i_rm,
        input  i_ready, i_clr_flags,
        output o_ready, o_valid, o_result, o_flag_ovf, o_flag_unf, o_flag_nx,
        output o_fflags
    );

    modport master (
        output i_valid, i_sign, i_exp, i_mant, i_overflow, i_underflow, i_rm,
        output i_ready, i_clr_flags,
        input  o_ready, o_valid, o_result, o_flag_ovf, o_flag_unf, o_flag_nx,
        input  o_fflags
    );

endinterface

// File: rtl/fpu_round_pack_incr.sv
// ---------------------------------------------------------------------------
// fpu_round_incr
// Combinational round-up decision for one mantissa.
//   rm        : rounding mode
//   sign      : result sign
//   lsb       : least significant kept fraction bit
//   guard     : first discarded bit
//   round_bit : second discarded bit
//   sticky    : OR of all remaining discarded bits
//   inc       : 1 when the kept mantissa must be incremented by one ulp
// ---------------------------------------------------------------------------
module fpu_round_incr
    import fpu_pkg::*;
(
    input  rm_e  rm,
    input  logic sign,
    input  logic lsb,
    input  logic guard,
    input  logic round_bit,
    input  logic sticky,
    output logic inc
);

    logic any_discarded;

    assign any_discarded = guard | round_bit | sticky;

    // Nearest-even rounds up above the halfway point, and at exactly halfway
    // only when that makes the kept LSB even. Directed modes round up in
    // magnitude whenever anything was discarded and the direction agrees
    // with the sign.
    always_comb begin
        inc = 1'b0;
        case (rm)
            RNE:     inc = guard & (round_bit | sticky | lsb);
            RTZ:     inc = 1'b0;
            RUP:     inc = ~sign & any_discarded;
            RDN:     inc = sign & any_discarded;
            default: inc = 1'b0;
        endcase
    end

endmodule

// File: rtl/fpu_round_pack.sv
// ---------------------------------------------------------------------------
// fpu_round_pack
// Two-stage rounding and packing of normalized add/sub results into IEEE
// single precision, with valid/ready flow control on both sides.
//   i_clk   : clock
//   i_rst_n : asynchronous active-low reset
//   bus     : fpu_round_pack_if.slave
//             in : i_valid/o_ready, i_sign, i_exp, i_mant, i_overflow,
//                  i_underflow, i_rm
//             out: o_valid/i_ready, o_result, o_flag_ovf/unf/nx
//             sticky: i_clr_flags, o_fflags {ovf, unf, nx}
// Stage 1 decides the round increment and adds it; stage 2 renormalizes a
// carry-out, applies zero/underflow/overflow special cases and packs.
// ---------------------------------------------------------------------------
module fpu_round_pack
    import fpu_pkg::*;
#(
    parameter int MANT_W = 28,
    parameter int EXP_W  = 8
)(
    input  logic           i_clk,
    input  logic           i_rst_n,
    fpu_round_pack_if.slave bus
);

    localparam int SUM_W = MANT_W - 3;

    logic             s1_adv;
    logic             out_fire;

    logic             s1_valid;
    logic [SUM_W-1:0] s1_sum;
    logic [EXP_W-1:0] s1_exp;
    logic             s1_sign;
    logic             s1_nx;
    logic             s1_ovf;
    logic             s1_unf;
    rm_e              s1_rm;
    logic             s1_zero;

    logic             s2_valid;
    logic [31:0]      s2_result;
    fflags_t          s2_flags;
    fflags_t          fflags_q;

    logic             inc;
    logic             in_any;
    logic [SUM_W-1:0] sum_in;

    logic [EXP_W:0]   exp_post;
    logic [22:0]      frac_post;
    logic [31:0]      result_next;
    fflags_t          flags_next;

    // Stage 2 can take a new entry when it is empty or its result leaves this
    // cycle; stage 1 accepts when it is empty or can move into stage 2.
    assign s1_adv      = ~s2_valid | bus.i_ready;
    assign bus.o_ready = ~s1_valid | s1_adv;
    assign out_fire    = s2_valid & bus.i_ready;

    assign in_any = bus.i_mant[3] | bus.i_mant[2] | (|bus.i_mant[1:0]);

    fpu_round_incr u_incr (
        .rm        (rm_e'(bus.i_rm)),
        .sign      (bus.i_sign),
        .lsb       (bus.i_mant[4]),
        .guard     (bus.i_mant[3]),
        .round_bit (bus.i_mant[2]),
        .sticky    (|bus.i_mant[1:0]),
        .inc       (inc)
    );

    // The extra top bit of the sum catches the all-ones + 1 carry-out.
    assign sum_in = {1'b0, bus.i_mant[MANT_W-1:4]} + SUM_W'(inc);

    // Stage 1 register: captures the rounded mantissa and the side-band
    // fields. When it is ready but nothing arrives, it simply empties.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid <= 1'b0;
            s1_sum   <= '0;
            s1_exp   <= '0;
            s1_sign  <= 1'b0;
            s1_nx    <= 1'b0;
            s1_ovf   <= 1'b0;
            s1_unf   <= 1'b0;
            s1_rm    <= RNE;
            s1_zero  <= 1'b0;
        end else if (bus.o_ready) begin
            s1_valid <= bus.i_valid;
            if (bus.i_valid) begin
                s1_sum  <= sum_in;
                s1_exp  <= bus.i_exp;
                s1_sign <= bus.i_sign;
                s1_nx   <= in_any;
                s1_ovf  <= bus.i_overflow;
                s1_unf  <= bus.i_underflow;
                s1_rm   <= rm_e'(bus.i_rm);
                s1_zero <= (bus.i_mant == '0);
            end
        end
    end

    // A rounding carry doubles the mantissa, so shift it back and bump the
    // exponent. The exponent keeps a spare bit so 255 + 1 cannot wrap.
    assign exp_post  = {1'b0, s1_exp} + (EXP_W+1)'(s1_sum[SUM_W-1]);
    assign frac_post = s1_sum[SUM_W-1] ? s1_sum[23:1] : s1_sum[22:0];

    // Special-case selection in priority order: exact zero, flush of an
    // underflowed value, overflow (from the normalizer or from rounding into
    // the all-ones exponent), then the ordinary packed value.
    always_comb begin
        result_next = {s1_sign, exp_post[7:0], frac_post};
        flags_next  = '{ovf: 1'b0, unf: 1'b0, nx: s1_nx};
        if (s1_zero) begin
            result_next = {s1_sign, 31'd0};
            flags_next  = '{ovf: 1'b0, unf: 1'b0, nx: 1'b0};
        end else if (s1_unf) begin
            result_next = {s1_sign, 31'd0};
            flags_next  = '{ovf: 1'b0, unf: 1'b1, nx: 1'b1};
        end else if (s1_ovf || (exp_post >= {1'b0, EXP_MAX})) begin
            result_next = {s1_sign, ovf_magnitude(s1_rm, s1_sign)};
            flags_next  = '{ovf: 1'b1, unf: 1'b0, nx: 1'b1};
        end
    end

    // Stage 2 register: this is the output register, so it only changes when
    // the held result has been taken or the stage is empty.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s2_valid  <= 1'b0;
            s2_result <= '0;
            s2_flags  <= '0;
        end else if (s1_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_result <= result_next;
                s2_flags  <= flags_next;
            end
        end
    end

    // Sticky flags: a clear wipes the history first, so flags of a result
    // leaving in the same cycle still survive.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fflags_q <= '0;
        end else begin
            fflags_q <= (bus.i_clr_flags ? fflags_t'(3'b000) : fflags_q)
                      | (out_fire ? s2_flags : fflags_t'(3'b000));
        end
    end

    assign bus.o_valid    = s2_valid;
    assign bus.o_result   = s2_result;
    assign bus.o_flag_ovf = s2_flags.ovf;
    assign bus.o_flag_unf = s2_flags.unf;
    assign bus.o_flag_nx  = s2_flags.nx;
    assign bus.o_fflags   = fflags_q;

endmodule

// File: tb/tb_fpu_round_pack.sv
// ---------------------------------------------------------------------------
// tb_fpu_round_pack
// Self-checking bench for fpu_round_pack: directed cases plus randomized
// traffic with random output stalls, checked against an arithmetic model of
// IEEE single rounding and a queue of expected results.
// ---------------------------------------------------------------------------
module tb_fpu_round_pack;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    fpu_round_pack_if bus ();

    fpu_round_pack dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int          checks = 0;
    int          failures = 0;
    logic [34:0] exp_q[$];
    logic [2:0]  ff_model = 3'b000;
    bit          rand_ready = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Reference rounding from the arithmetic definition: the discarded low
    // nibble is compared against one half ulp (8), then the kept value is
    // renormalized if it reaches 2^24. Returns {result, ovf, unf, nx}.
    function automatic logic [34:0] model(input logic s, input logic [7:0] e,
                                          input logic [27:0] m, input logic ov,
                                          input logic un, input logic [1:0] rm);
        logic [31:0] trunc, rem, t, ee;
        logic        up, to_inf;
        logic [30:0] mag;
        if (m == 0) return {s, 31'd0, 3'b000};
        if (un) return {s, 31'd0, 3'b011};
        trunc = 32'(m) / 16;
        rem   = 32'(m) % 16;
        case (rm)
            2'd0:    up = (rem > 8) || (rem == 8 && (trunc % 2) == 1);
            2'd1:    up = 1'b0;
            2'd2:    up = (rem != 0) && !s;
            default: up = (rem != 0) && s;
        endcase
        t  = trunc + 32'(up);
        ee = 32'(e);
        if (t >= 32'h0100_0000) begin
            t  = t / 2;
            ee = ee + 1;
        end
        if (ov || ee >= 255) begin
            to_inf = (rm == 2'd0) || (rm == 2'd2 && !s) || (rm == 2'd3 && s);
            mag    = to_inf ? 31'h7F800000 : 31'h7F7FFFFF;
            return {s, mag, 3'b101};
        end
        return {s, ee[7:0], t[22:0], 2'b00, (rem != 0)};
    endfunction

    // Per-cycle scoreboard, sampled on the falling edge: check the held
    // output against the oldest expected entry, track sticky flags, and
    // queue a model result for any input that will transfer at the next edge.
    task automatic sample_cycle();
        logic [34:0] e;
        logic        fire;
        logic [2:0]  fl;
        if (!rst_n) begin
            exp_q.delete();
            ff_model = 3'b000;
            return;
        end
        chk("fflags", 64'(bus.o_fflags), 64'(ff_model));
        fire = 1'b0;
        fl   = 3'b000;
        if (bus.o_valid) begin
            chk("output_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                e = exp_q[0];
                chk("result", 64'(bus.o_result), 64'(e[34:3]));
                chk("flags", 64'({bus.o_flag_ovf, bus.o_flag_unf, bus.o_flag_nx}), 64'(e[2:0]));
                if (bus.i_ready) begin
                    fire = 1'b1;
                    fl   = e[2:0];
                    void'(exp_q.pop_front());
                end
            end
        end
        ff_model = (bus.i_clr_flags ? 3'b000 : ff_model) | (fire ? fl : 3'b000);
        if (bus.i_valid && bus.o_ready)
            exp_q.push_back(model(bus.i_sign, bus.i_exp, bus.i_mant, bus.i_overflow,
                                  bus.i_underflow, bus.i_rm));
    endtask

    task automatic tick();
        @(negedge clk);
        sample_cycle();
        @(posedge clk);
        #1;
        if (rand_ready) bus.i_ready = ($urandom_range(0, 3) != 0);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic [7:0] e, input logic [27:0] m,
                                 input logic ov, input logic un, input logic [1:0] rm);
        int n;
        bus.i_sign      = s;
        bus.i_exp       = e;
        bus.i_mant      = m;
        bus.i_overflow  = ov;
        bus.i_underflow = un;
        bus.i_rm        = rm;
        bus.i_valid     = 1'b1;
        n = 0;
        while (!bus.o_ready && n < 100) begin
            tick();
            n++;
        end
        chk("input_accept_timeout", 64'(n < 100), 64'd1);
        tick();
        bus.i_valid = 1'b0;
    endtask

    // Directed single transaction through an empty pipe with i_ready high.
    task automatic checkOutput(input string tag, input logic s, input logic [7:0] e,
                               input logic [27:0] m, input logic ov, input logic un,
                               input logic [1:0] rm, input logic [31:0] res,
                               input logic [2:0] fl);
        int lat;
        applyStimulus(s, e, m, ov, un, rm);
        lat = 1;
        while (!bus.o_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'd2);
        chk({tag, "_result"}, 64'(bus.o_result), 64'(res));
        chk({tag, "_flags"}, 64'({bus.o_flag_ovf, bus.o_flag_unf, bus.o_flag_nx}), 64'(fl));
        tick();
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.o_valid) && n < 200) begin
            tick();
            n++;
        end
        chk({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        logic [27:0] rm_mant;
        logic [7:0]  r_exp;
        logic        r_ov, r_un;
        int          sel, n;

        bus.i_valid     = 1'b0;
        bus.i_sign      = 1'b0;
        bus.i_exp       = '0;
        bus.i_mant      = '0;
        bus.i_overflow  = 1'b0;
        bus.i_underflow = 1'b0;
        bus.i_rm        = 2'd0;
        bus.i_ready     = 1'b1;
        bus.i_clr_flags = 1'b0;

        #12;
        chk("reset_o_valid", 64'(bus.o_valid), 64'd0);
        chk("reset_o_result", 64'(bus.o_result), 64'd0);
        chk("reset_o_fflags", 64'(bus.o_fflags), 64'd0);
        chk("reset_o_ready", 64'(bus.o_ready), 64'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        checkOutput("tie_even", 1'b0, 8'h7F, 28'h8000008, 1'b0, 1'b0, 2'd0, 32'h3F800000, 3'b001);
        checkOutput("carry_out", 1'b0, 8'h7F, 28'hFFFFFF8, 1'b0, 1'b0, 2'd0, 32'h40000000, 3'b001);
        checkOutput("round_ovf", 1'b0, 8'hFE, 28'hFFFFFF8, 1'b0, 1'b0, 2'd0, 32'h7F800000, 3'b101);
        checkOutput("ovf_rtz", 1'b0, 8'hFE, 28'h8000000, 1'b1, 1'b0, 2'd1, 32'h7F7FFFFF, 3'b101);
        checkOutput("ovf_rup_neg", 1'b1, 8'h80, 28'h8000000, 1'b1, 1'b0, 2'd2, 32'hFF7FFFFF, 3'b101);
        checkOutput("ovf_rdn_neg", 1'b1, 8'h80, 28'h8000000, 1'b1, 1'b0, 2'd3, 32'hFF800000, 3'b101);
        checkOutput("flush", 1'b1, 8'h00, 28'h4000000, 1'b0, 1'b1, 2'd0, 32'h80000000, 3'b011);
        checkOutput("zero", 1'b0, 8'h00, 28'h0000000, 1'b0, 1'b0, 2'd0, 32'h00000000, 3'b000);
        checkOutput("rup_pos", 1'b0, 8'h80, 28'h8000001, 1'b0, 1'b0, 2'd2, 32'h40000001, 3'b001);
        checkOutput("exact", 1'b1, 8'h81, 28'hC000000, 1'b0, 1'b0, 2'd0, 32'hC0C00000, 3'b000);

        // Backpressure: two results fill the pipe, the third must wait.
        bus.i_ready = 1'b0;
        bus.i_sign = 1'b0; bus.i_exp = 8'h90; bus.i_mant = 28'h9000010;
        bus.i_overflow = 1'b0; bus.i_underflow = 1'b0; bus.i_rm = 2'd0;
        bus.i_valid = 1'b1;
        tick();
        bus.i_sign = 1'b1; bus.i_exp = 8'h91; bus.i_mant = 28'hA00001C;
        tick();
        bus.i_sign = 1'b0; bus.i_exp = 8'h92; bus.i_mant = 28'hB000004; bus.i_rm = 2'd2;
        chk("bp_o_ready_low", 64'(bus.o_ready), 64'd0);
        chk("bp_o_valid_held", 64'(bus.o_valid), 64'd1);
        repeat (3) tick();
        bus.i_ready = 1'b1;
        tick();
        bus.i_sign = 1'b1; bus.i_exp = 8'h93; bus.i_mant = 28'hC000018; bus.i_rm = 2'd3;
        tick();
        bus.i_valid = 1'b0;
        drain("bp");

        // Clear in the same cycle as an inexact-only result transfers.
        bus.i_ready = 1'b0;
        applyStimulus(1'b0, 8'h80, 28'h8000001, 1'b0, 1'b0, 2'd0);
        n = 0;
        while (!bus.o_valid && n < 20) begin
            tick();
            n++;
        end
        chk("clr_o_valid", 64'(bus.o_valid), 64'd1);
        bus.i_clr_flags = 1'b1;
        bus.i_ready = 1'b1;
        tick();
        bus.i_clr_flags = 1'b0;
        chk("clr_with_nx", 64'(bus.o_fflags), 64'd1);

        // Randomized traffic with random output stalls.
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            sel     = $urandom_range(0, 15);
            rm_mant = {1'b1, 27'($urandom)};
            r_exp   = 8'($urandom_range(1, 254));
            r_ov    = 1'b0;
            r_un    = 1'b0;
            if (sel == 0) rm_mant = '0;
            if (sel == 1) begin r_un = 1'b1; r_exp = 8'h00; end
            if (sel == 2) r_ov = 1'b1;
            if (sel == 3) r_exp = 8'hFE;
            if (sel == 4) rm_mant[26:4] = '1;
            bus.i_clr_flags = ($urandom_range(0, 15) == 0);
            applyStimulus(1'($urandom), r_exp, rm_mant, r_ov, r_un, 2'($urandom));
            bus.i_clr_flags = 1'b0;
        end
        rand_ready = 1'b0;
        bus.i_ready = 1'b1;
        drain("random");

        // Asynchronous reset while a result is being held.
        bus.i_ready = 1'b0;
        applyStimulus(1'b0, 8'h85, 28'hFFFFFFF, 1'b0, 1'b0, 2'd0);
        n = 0;
        while (!bus.o_valid && n < 20) begin
            tick();
            n++;
        end
        chk("pre_reset_o_valid", 64'(bus.o_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_o_valid", 64'(bus.o_valid), 64'd0);
        chk("async_rst_o_result", 64'(bus.o_result), 64'd0);
        chk("async_rst_o_fflags", 64'(bus.o_fflags), 64'd0);
        chk("async_rst_o_ready", 64'(bus.o_ready), 64'd1);
        tick();
        tick();
        rst_n = 1'b1;
        bus.i_ready = 1'b1;
        chk("post_rst_o_ready", 64'(bus.o_ready), 64'd1);
        checkOutput("post_rst", 1'b0, 8'h7F, 28'hFFFFFF8, 1'b0, 1'b0, 2'd0, 32'h40000000, 3'b001);
        drain("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fpu_round_pack.md
Name: fpu_round_pack

Overview:
- Pipelined rounding and packing stage directly downstream of the add/sub normalizer in the single-precision FPU datapath.
- Consumes the normalizer's sign, exponent, 28-bit mantissa and overflow/underflow flags, and applies the selected IEEE-754 rounding mode.
- Emits a packed 32-bit IEEE single result with per-result flags plus sticky accumulated flags.
- Valid/ready handshake on both sides; 2-stage pipeline with full backpressure.

Parameters:
- MANT_W, 28, input mantissa width: hidden bit [27], fraction [26:4], guard [3], round [2], sticky bits [1:0].
- EXP_W, 8, biased exponent width.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  upstream result valid
- o_ready  out  1  stage can accept input
- i_sign  in  1  result sign
- i_exp  in  8  biased exponent from normalizer
- i_mant  in  28  normalized mantissa with G/R/S
- i_overflow  in  1  normalizer overflow
- i_underflow  in  1  normalizer underflow (exponent floored to 0)
- i_rm  in  2  rounding mode: 0 RNE, 1 RTZ, 2 RUP (+inf), 3 RDN (-inf)
- o_valid  out  1  packed result valid
- i_ready  in  1  downstream accepts result
- o_result  out  32  IEEE single {sign, exp[7:0], frac[22:0]}
- o_flag_ovf  out  1  overflow for this result
- o_flag_unf  out  1  underflow for this result
- o_flag_nx  out  1  inexact for this result
- i_clr_flags  in  1  clear sticky flags
- o_fflags  out  3  sticky {ovf, unf, nx}

Behaviour:
- Reset (async, i_rst_n=0):
  - Stage valids, o_valid, o_result, per-result flags and o_fflags all go to 0 immediately.
  - o_ready=1 once the stages are empty.
- Handshake:
  - Input transfer on i_valid & o_ready. Output transfer on o_valid & i_ready.
  - o_ready = ~s1_valid | s1_adv, where s1_adv = ~s2_valid | i_ready.
  - Latency 2 cycles from input transfer to o_valid with no stall; throughput 1 per cycle.
  - While o_valid & ~i_ready, o_result and the flags are held stable. No loss, no duplication, order preserved.
- Stage 1 (registered on transfer):
  - grs = {i_mant[3], i_mant[2], |i_mant[1:0]}; lsb = i_mant[4]; any = |grs.
  - inc: RNE = G & (R|S|lsb); RTZ = 0; RUP = ~sign & any; RDN = sign & any.
  - Register sum[24:0] = {1'b0, i_mant[27:4]} + inc.
  - Also register exp, sign, nx = any, ovf_in, unf_in, rm, and zero = (i_mant == 0).
- Stage 2 (registered on s1_adv):
  - If sum[24]: frac = sum[23:1], exp = exp + 1; otherwise frac = sum[22:0].
  - Priority 1, zero: result {sign, 31'b0}, all flags 0.
  - Priority 2, unf_in with nonzero mantissa: flush to {sign, 31'b0}; unf = 1, nx = 1.
  - Priority 3, ovf_in, or the post-round exponent reaches 8'hFF (including the 254 → 255 rounding carry): ovf = 1, nx = 1. Result by mode:
    - RNE: ±inf.
    - RTZ: ±0x7F7FFFFF (max finite).
    - RUP: +inf if positive, -max finite if negative.
    - RDN: -inf if negative, +max finite if positive.
  - Otherwise: {sign, exp, frac}; nx from stage 1.
- Sticky flags:
  - On each output transfer, o_fflags |= {ovf, unf, nx}.
  - i_clr_flags zeroes o_fflags. If a clear and a flag-setting transfer occur in the same cycle, the new flags are set after the clear.
- Reset mid-operation discards all in-flight results.

Decomposition:
- fpu_pkg holds:
  - rounding-mode enum rm_e (RNE, RTZ, RUP, RDN);
  - constants EXP_MAX = 8'hFF, MAX_FINITE = 31'h7F7FFFFF, POS_INF = 31'h7F800000;
  - flag-struct typedef fflags_t {ovf, unf, nx}.
- One sub-module, fpu_round_incr: combinational increment decision (inputs rm, sign, lsb, G, R, S; output inc).

Test Plan:
- Tie to even, no increment: sign 0, exp 0x7F, mant 0x8000008, RNE → o_result 0x3F800000, nx = 1, ovf = 0, unf = 0, latency 2.
- Rounding carry-out: exp 0x7F, mant 0xFFFFFF8, RNE → 0x40000000, nx = 1.
- Overflow by rounding: exp 0xFE, mant 0xFFFFFF8, RNE → 0x7F800000, ovf = 1, nx = 1. Then i_overflow = 1, RTZ, sign 0 → 0x7F7FFFFF, ovf = 1.
- Flush-to-zero and exact zero:
  - exp 0, mant 0x4000000, i_underflow 1, sign 1 → 0x80000000, unf = 1, nx = 1.
  - mant 0 → 0x00000000 with all flags 0.
- Backpressure: 4 back-to-back inputs with i_ready low for 3 cycles → o_ready drops once 2 results are held, o_result stable while stalled, all 4 results emitted in order. Then i_clr_flags pulsed in the same cycle as an nx transfer → o_fflags = 3'b001.
- Async reset asserted while o_valid = 1 → o_valid, o_result and o_fflags are 0 before the next clock edge. After release, o_ready = 1 and the next input produces the correct result.
